// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED control, PC update and retired-instruction counting.
// Define PC_BRANCH_COUNT_EN to add the saturating taken-branch counter and its branch_count port.
module pc_sequencer #(
  parameter int unsigned D     = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_instr,
  input  logic             branch_en,
  input  logic [D-1:0]     target,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
`ifdef PC_BRANCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] branch_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
`ifdef PC_BRANCH_COUNT_EN
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, PC and counter update; stall outranks halt, halt outranks branch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icnt_d  = icnt_q;
`ifdef PC_BRANCH_COUNT_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          icnt_d = sat_inc(icnt_q);
          if (halt_instr) begin
            state_d = ST_HALTED;
          end else if (branch_en) begin
            pc_d = pc_q + target;
`ifdef PC_BRANCH_COUNT_EN
            bcnt_d = sat_inc(bcnt_q);
`endif
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          icnt_d  = '0;
`ifdef PC_BRANCH_COUNT_EN
          bcnt_d  = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      icnt_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
      bcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      icnt_q    <= icnt_d;
      running_q <= running_d;
      done_q    <= done_d;
`ifdef PC_BRANCH_COUNT_EN
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  assign prog_ctr    = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign instr_count = icnt_q;
`ifdef PC_BRANCH_COUNT_EN
  assign branch_count = bcnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against an arithmetic reference model.
// A second instance with 4-bit counters exercises saturation quickly.
module tb_pc_sequencer;

  localparam int unsigned D       = 12;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_WS  = 4;
  localparam int          PC_MOD  = 1 << D;
  localparam int          MAX_BIG = (1 << CNT_W) - 1;
  localparam int          MAX_SML = (1 << CNT_WS) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, stall, halt_instr, branch_en;
  logic [D-1:0]      target;
  logic [D-1:0]      prog_ctr, prog_ctr_s;
  logic              running, done, running_s, done_s;
  logic [CNT_W-1:0]  instr_count;
  logic [CNT_WS-1:0] instr_count_s;
`ifdef PC_BRANCH_COUNT_EN
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_WS-1:0] branch_count_s;
`endif

  pc_sequencer #(.D(D), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt_instr(halt_instr), .branch_en(branch_en), .target(target),
    .prog_ctr(prog_ctr), .running(running), .done(done),
    .instr_count(instr_count)
`ifdef PC_BRANCH_COUNT_EN
    , .branch_count(branch_count)
`endif
  );

  pc_sequencer #(.D(D), .CNT_W(CNT_WS)) u_small (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt_instr(halt_instr), .branch_en(branch_en), .target(target),
    .prog_ctr(prog_ctr_s), .running(running_s), .done(done_s),
    .instr_count(instr_count_s)
`ifdef PC_BRANCH_COUNT_EN
    , .branch_count(branch_count_s)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: mode 0=idle 1=run 2=halted; counts kept as plain integers then clipped.
  int m_mode, m_pc, m_retired, m_taken;

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_retired = 0; m_taken = 0;
  endtask

  task automatic model_edge();
    int off;
    if (m_mode == 0) begin
      m_pc = 0;
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!stall) begin
        m_retired++;
        if (halt_instr) m_mode = 2;
        else if (branch_en) begin
          off = int'($signed(target));
          m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
          m_taken++;
        end else m_pc = (m_pc + 1) % PC_MOD;
      end
    end else if (start) begin
      m_mode = 1; m_pc = 0; m_retired = 0; m_taken = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},   32'(prog_ctr),      32'(m_pc));
    check({tag, ".run"},  32'(running),       32'(m_mode == 1));
    check({tag, ".done"}, 32'(done),          32'(m_mode == 2));
    check({tag, ".ic"},   32'(instr_count),   32'(clip(m_retired, MAX_BIG)));
    check({tag, ".pcs"},  32'(prog_ctr_s),    32'(m_pc));
    check({tag, ".ics"},  32'(instr_count_s), 32'(clip(m_retired, MAX_SML)));
`ifdef PC_BRANCH_COUNT_EN
    check({tag, ".bc"},   32'(branch_count),  32'(clip(m_taken, MAX_BIG)));
    check({tag, ".bcs"},  32'(branch_count_s), 32'(clip(m_taken, MAX_SML)));
`endif
  endtask

  // Drive inputs, take one clock edge, then compare just after it.
  task automatic cycle(input string tag, input logic st, input logic sl, input logic hl,
                       input logic br, input logic [D-1:0] tg);
    start = st; stall = sl; halt_instr = hl; branch_en = br; target = tg;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run_plain(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; stall = 1'b0; halt_instr = 1'b0; branch_en = 1'b0; target = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check_all("rst");
  endtask

  // Reset raised between clock edges must clear outputs with no edge in between.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk); #1;
    reset = 1'b0;
    check_all({tag, ".rel"});
  endtask

  initial begin
    do_reset();

    // 1: start then free-run
    cycle("t1s", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t1_pc0", 32'(prog_ctr), 32'd0);
    run_plain("t1", 5);
    check("t1_pc5", 32'(prog_ctr), 32'd5);
    check("t1_ic5", 32'(instr_count), 32'd5);
    check("t1_run", 32'(running), 32'd1);

    // 2: backward branch wrapping below zero, then forward branch
    do_reset();
    cycle("t2s", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_plain("t2a", 3);
    cycle("t2b1", 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFB);
    check("t2_wrap", 32'(prog_ctr), 32'h0FFE);
    run_plain("t2b", 12);
    check("t2_pc10", 32'(prog_ctr), 32'd10);
    cycle("t2b2", 1'b0, 1'b0, 1'b0, 1'b1, 12'h014);
    check("t2_pc30", 32'(prog_ctr), 32'd30);
`ifdef PC_BRANCH_COUNT_EN
    check("t2_bc2", 32'(branch_count), 32'd2);
`endif

    // 3: stall masks halt and branch, then halt retires
    cycle("t3j", 1'b0, 1'b0, 1'b0, 1'b1, 12'hFE9);
    check("t3_pc7", 32'(prog_ctr), 32'd7);
    for (int i = 0; i < 3; i++) cycle("t3st", 1'b0, 1'b1, 1'b1, 1'b1, 12'h055);
    check("t3_hold", 32'(prog_ctr), 32'd7);
    cycle("t3h", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_pch", 32'(prog_ctr), 32'd7);

    // 4: halt wins over a simultaneous branch
    cycle("t4s", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_plain("t4", 20);
    cycle("t4h", 1'b0, 1'b0, 1'b1, 1'b1, 12'h00D);
    check("t4_pc20", 32'(prog_ctr), 32'd20);
    check("t4_done", 32'(done), 32'd1);

    // 5: restart from HALTED clears PC and counters
    cycle("t5s", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_plain("t5", 41);
    cycle("t5h", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("t5_ic42", 32'(instr_count), 32'd42);
    check("t5_sat", 32'(instr_count_s), 32'd15);
    cycle("t5r", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t5_run", 32'(running), 32'd1);
    check("t5_ndone", 32'(done), 32'd0);
    check("t5_pc0", 32'(prog_ctr), 32'd0);
    check("t5_ic0", 32'(instr_count), 32'd0);

    // 6: asynchronous reset mid-run, plus narrow counter stays saturated
    run_plain("t6", 100);
    check("t6_pc100", 32'(prog_ctr), 32'd100);
    check("t6_sat", 32'(instr_count_s), 32'd15);
    async_reset("t6ar");
    check("t6_pcz", 32'(prog_ctr), 32'd0);
    check("t6_idle", 32'(running), 32'd0);

    // zero-offset spin loop retires without moving
    cycle("spin_s", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle("spin", 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    check("spin_pc", 32'(prog_ctr), 32'd0);
    check("spin_ic", 32'(instr_count), 32'd4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset("rnd_ar");
      cycle("rnd",
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 3) == 0),
            D'($urandom_range(0, PC_MOD - 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
